// File: rtl/hypercorex_inst_decoder.sv
// Registered decode stage for Hypercorex instruction words. A two-entry skid buffer
// keeps upstream ready registered while still sustaining one word per cycle.
module hypercorex_inst_decoder #(
    parameter int unsigned CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [31:0]         inst_i,
    input  logic                inst_valid_i,
    output logic                inst_ready_o,
    output logic                dec_valid_o,
    input  logic                dec_ready_i,
    output logic [2:0]          type_o,
    output logic [3:0]          func_o,
    output logic [1:0]          rd_o,
    output logic [1:0]          rs1_o,
    output logic [1:0]          rs2_o,
    output logic [1:0]          shift_amt_o,
    output logic [2:0]          dst_sel_o,
    output logic                err_o,
    input  logic                err_clr_i,
    output logic [CntWidth-1:0] inst_cnt_o,
    output logic [CntWidth-1:0] illegal_cnt_o
);

    localparam logic [2:0] DstReg   = 3'd1;
    localparam logic [2:0] DstBundA = 3'd2;
    localparam logic [2:0] DstBundB = 3'd3;
    localparam logic [2:0] DstQhv   = 3'd4;
    localparam logic [2:0] DstAm    = 3'd5;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    typedef struct packed {
        logic [2:0] typ;
        logic [3:0] func;
        logic [1:0] shamt;
        logic [1:0] rs2;
        logic [1:0] rs1;
        logic [1:0] rd;
        logic [2:0] dst;
    } entry_t;

    state_t              r_state, w_state_next;
    entry_t              r_out, r_skid, w_dec;
    logic [3:0]          w_func_max;
    logic                w_legal, w_accept, w_acc_legal, w_acc_illegal, w_out_hs;
    logic                r_ready, r_err, w_err_next;
    logic [CntWidth-1:0] r_inst_cnt, r_illegal_cnt;

    // Field split and legality check; the top of each type's func range sets legality.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_dec       = '0;
        w_dec.typ   = inst_i[10:8];
        w_dec.func  = inst_i[14:11];
        w_dec.shamt = inst_i[7:6];
        w_dec.rs2   = inst_i[5:4];
        w_dec.rs1   = inst_i[3:2];
        w_dec.rd    = inst_i[1:0];
        w_func_max  = 4'd0;
        unique case (w_dec.typ)
            3'd0: begin w_func_max = 4'd4;  w_dec.dst = DstReg; end
            3'd1: begin w_func_max = 4'd2;  w_dec.dst = DstReg; end
            3'd2: begin
                w_func_max = 4'd6;
                w_dec.dst  = w_dec.func[0] ? DstBundA : DstBundB;
            end
            3'd3: begin w_func_max = 4'd3;  w_dec.dst = DstReg; end
            3'd4: begin
                w_func_max = 4'd12;
                case (w_dec.func)
                    4'd1, 4'd3, 4'd11: w_dec.dst = DstBundA;
                    4'd2, 4'd4, 4'd12: w_dec.dst = DstBundB;
                    default:           w_dec.dst = DstReg;
                endcase
            end
            3'd5: begin
                w_func_max = 4'd4;
                w_dec.dst  = (w_dec.func == 4'd1 || w_dec.func == 4'd4) ? DstBundB : DstBundA;
            end
            3'd6: begin w_func_max = 4'd4;  w_dec.dst = DstQhv; end
            default: begin w_func_max = 4'd2; w_dec.dst = DstAm; end
        endcase
        w_legal = (w_dec.func != 4'd0) && (w_dec.func <= w_func_max);
    end

    assign w_accept      = inst_valid_i && r_ready;
    assign w_acc_legal   = w_accept && w_legal;
    assign w_acc_illegal = w_accept && !w_legal;
    assign w_out_hs      = dec_valid_o && dec_ready_i;
    // Setting on an illegal accept outranks a clear in the same cycle.
    assign w_err_next    = w_acc_illegal ? 1'b1 : (err_clr_i ? 1'b0 : r_err);

    always_comb begin
        w_state_next = r_state;
        dec_valid_o  = (r_state != ST_EMPTY);
        unique case (r_state)
            ST_EMPTY: if (w_acc_legal) w_state_next = ST_ONE;
            ST_ONE: begin
                if (w_out_hs && !w_acc_legal)      w_state_next = ST_EMPTY;
                else if (w_acc_legal && !w_out_hs) w_state_next = ST_FULL;
            end
            default: if (w_out_hs) w_state_next = ST_ONE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: both entries are cleared too, so outputs read 0 after reset and stale words vanish.
            r_state       <= ST_EMPTY;
            r_out         <= '0;
            r_skid        <= '0;
            r_ready       <= 1'b0;
            r_err         <= 1'b0;
            r_inst_cnt    <= '0;
            r_illegal_cnt <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so all registers see pre-edge values.
            r_state <= w_state_next;
            r_ready <= (w_state_next != ST_FULL) && !w_err_next;
            r_err   <= w_err_next;
            unique case (r_state)
                ST_EMPTY: if (w_acc_legal) r_out <= w_dec;
                ST_ONE: begin
                    if (w_acc_legal && w_out_hs) r_out  <= w_dec;
                    else if (w_acc_legal)        r_skid <= w_dec;
                end
                default: if (w_out_hs) r_out <= r_skid;
            endcase
            if (w_acc_legal && (r_inst_cnt != '1))
                r_inst_cnt <= r_inst_cnt + CntWidth'(1);
            if (w_acc_illegal && (r_illegal_cnt != '1))
                r_illegal_cnt <= r_illegal_cnt + CntWidth'(1);
        end
    end

    assign inst_ready_o  = r_ready;
    assign type_o        = r_out.typ;
    assign func_o        = r_out.func;
    assign rd_o          = r_out.rd;
    assign rs1_o         = r_out.rs1;
    assign rs2_o         = r_out.rs2;
    assign shift_amt_o   = r_out.shamt;
    assign dst_sel_o     = r_out.dst;
    assign err_o         = r_err;
    assign inst_cnt_o    = r_inst_cnt;
    assign illegal_cnt_o = r_illegal_cnt;

endmodule

// File: tb/tb_hypercorex_inst_decoder.sv
// Directed bench for hypercorex_inst_decoder: vector table, full type x func sweep,
// plus backpressure, error, reset and counter-saturation sequences.
module tb_hypercorex_inst_decoder;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] inst;
    logic        inst_valid, dec_ready, err_clr;
    logic        inst_ready_o, dec_valid_o, err_o;
    logic [2:0]  type_o, dst_sel_o;
    logic [3:0]  func_o;
    logic [1:0]  rd_o, rs1_o, rs2_o, shift_amt_o;
    logic [31:0] inst_cnt_o, illegal_cnt_o;

    logic [31:0] inst2;
    logic        valid2, dready2, clr2, ready2, dvalid2, err2;
    logic [2:0]  type2, dst2;
    logic [3:0]  func2;
    logic [1:0]  rd2, rs12, rs22, sh2;
    logic [1:0]  icnt2, ill2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hypercorex_inst_decoder #(.CntWidth(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .inst_i(inst), .inst_valid_i(inst_valid),
        .inst_ready_o(inst_ready_o), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready),
        .type_o(type_o), .func_o(func_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .shift_amt_o(shift_amt_o), .dst_sel_o(dst_sel_o), .err_o(err_o), .err_clr_i(err_clr),
        .inst_cnt_o(inst_cnt_o), .illegal_cnt_o(illegal_cnt_o)
    );

    hypercorex_inst_decoder #(.CntWidth(2)) u_dut_sat (
        .clk_i(clk), .rst_ni(rst_ni), .inst_i(inst2), .inst_valid_i(valid2),
        .inst_ready_o(ready2), .dec_valid_o(dvalid2), .dec_ready_i(dready2),
        .type_o(type2), .func_o(func2), .rd_o(rd2), .rs1_o(rs12), .rs2_o(rs22),
        .shift_amt_o(sh2), .dst_sel_o(dst2), .err_o(err2), .err_clr_i(clr2),
        .inst_cnt_o(icnt2), .illegal_cnt_o(ill2)
    );

    typedef struct {
        logic [31:0] inst;
        bit          legal;
        logic [2:0]  dst;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference legality and destination, written as func-range tables.
    function automatic bit ref_legal(input logic [2:0] t, input logic [3:0] f);
        int max_f [8] = '{4, 2, 6, 3, 12, 4, 4, 2};
        return (f >= 1) && (int'(f) <= max_f[t]);
    endfunction

    function automatic logic [2:0] ref_dst(input logic [2:0] t, input logic [3:0] f);
        case (t)
            3'd2:    return f[0] ? 3'd2 : 3'd3;
            3'd4:    return (f == 1 || f == 3 || f == 11) ? 3'd2 :
                            (f == 2 || f == 4 || f == 12) ? 3'd3 : 3'd1;
            3'd5:    return (f == 1 || f == 4) ? 3'd3 : 3'd2;
            3'd6:    return 3'd4;
            3'd7:    return 3'd5;
            default: return 3'd1;
        endcase
    endfunction

    task automatic send_word(input logic [31:0] w);
        int t = 0;
        while (!inst_ready_o && t < 20) begin
            step();
            t++;
        end
        if (!inst_ready_o) check("ready_timeout", 32'(inst_ready_o), 32'd1);
        inst       = w;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
    endtask

    task automatic check_word(input logic [31:0] w, input bit legal, input logic [2:0] dst);
        send_word(w);
        if (legal) begin
            check("word_valid", 32'(dec_valid_o), 32'd1);
            check("word_type",  32'(type_o),      32'(w[10:8]));
            check("word_func",  32'(func_o),      32'(w[14:11]));
            check("word_regs",  32'({shift_amt_o, rs2_o, rs1_o, rd_o}), 32'(w[7:0]));
            check("word_dst",   32'(dst_sel_o),   32'(dst));
            check("word_noerr", 32'(err_o),       32'd0);
        end else begin
            check("illegal_err",   32'(err_o),        32'd1);
            check("illegal_ready", 32'(inst_ready_o), 32'd0);
            check("illegal_drop",  32'(dec_valid_o),  32'd0);
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            check("illegal_clr", 32'(err_o), 32'd0);
        end
    endtask

    initial begin
        int idx, tl, ti;
        bit will_acc;
        logic [2:0] t3;
        logic [3:0] f4;

        vecs[0]  = '{32'h0000_0808, 1'b1, 3'd1};
        vecs[1]  = '{32'h0000_207E, 1'b1, 3'd1};
        vecs[2]  = '{32'h0000_6400, 1'b1, 3'd3};
        vecs[3]  = '{32'h0000_1A00, 1'b1, 3'd2};
        vecs[4]  = '{32'h0000_3200, 1'b1, 3'd3};
        vecs[5]  = '{32'h0000_3A00, 1'b0, 3'd0};
        vecs[6]  = '{32'h0000_3C00, 1'b1, 3'd1};
        vecs[7]  = '{32'h0000_5C00, 1'b1, 3'd2};
        vecs[8]  = '{32'h0000_6C00, 1'b0, 3'd0};
        vecs[9]  = '{32'h0000_0D00, 1'b1, 3'd3};
        vecs[10] = '{32'h0000_1500, 1'b1, 3'd2};
        vecs[11] = '{32'h0000_2600, 1'b1, 3'd4};
        vecs[12] = '{32'h0000_1F00, 1'b0, 3'd0};
        vecs[13] = '{32'hFFF8_1BE4, 1'b1, 3'd1};

        rst_ni = 1'b0; inst = '0; inst_valid = 1'b0; dec_ready = 1'b1; err_clr = 1'b0;
        inst2 = '0; valid2 = 1'b0; dready2 = 1'b1; clr2 = 1'b0;

        step();
        step();
        check("rst_ready",   32'(inst_ready_o), 32'd0);
        check("rst_valid",   32'(dec_valid_o),  32'd0);
        check("rst_fields",  32'({type_o, func_o, shift_amt_o, rs2_o, rs1_o, rd_o, dst_sel_o}), 32'd0);
        check("rst_err",     32'(err_o),        32'd0);
        check("rst_cnt",     inst_cnt_o,        32'd0);
        check("rst_illcnt",  illegal_cnt_o,     32'd0);
        rst_ni = 1'b1;
        step();
        check("ready_rise", 32'(inst_ready_o), 32'd1);

        // Back-to-back stream at full throughput.
        inst = 32'h0000_0808; inst_valid = 1'b1;
        step();
        check("s0_valid", 32'(dec_valid_o), 32'd1);
        check("s0_dst",   32'(dst_sel_o),   32'd1);
        check("s0_regs",  32'({shift_amt_o, rs2_o, rs1_o, rd_o}), 32'h08);
        check("s0_ready", 32'(inst_ready_o), 32'd1);
        inst = 32'h0000_207E;
        step();
        inst_valid = 1'b0;
        check("s1_valid", 32'(dec_valid_o), 32'd1);
        check("s1_func",  32'(func_o),      32'd4);
        check("s1_dst",   32'(dst_sel_o),   32'd1);
        check("s1_regs",  32'({shift_amt_o, rs2_o, rs1_o, rd_o}), 32'h7E);
        step();
        check("s_drain", 32'(dec_valid_o), 32'd0);
        check("s_cnt",   inst_cnt_o,       32'd2);

        // Backpressure: three words offered, only two fit.
        dec_ready = 1'b0; idx = 0; inst_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            inst = (idx == 0) ? 32'h0000_0808 : (idx == 1) ? 32'h0000_1A00 : 32'h0000_2600;
            will_acc = inst_ready_o;
            step();
            if (will_acc) idx++;
        end
        check("bp_accepted", 32'(idx),          32'd2);
        check("bp_ready",    32'(inst_ready_o), 32'd0);
        check("bp_hold_dst", 32'(dst_sel_o),    32'd1);
        check("bp_hold_fn",  32'(func_o),       32'd1);
        dec_ready = 1'b1;
        step();
        check("bp_w1_dst",   32'(dst_sel_o),    32'd2);
        check("bp_w1_ready", 32'(inst_ready_o), 32'd1);
        step();
        inst_valid = 1'b0;
        check("bp_w2_valid", 32'(dec_valid_o), 32'd1);
        check("bp_w2_dst",   32'(dst_sel_o),   32'd4);
        step();
        check("bp_drain", 32'(dec_valid_o), 32'd0);
        check("bp_cnt",   inst_cnt_o,       32'd5);

        // Reset while the buffer is full.
        dec_ready = 1'b0;
        send_word(32'h0000_0808);
        send_word(32'h0000_1500);
        check("full_ready", 32'(inst_ready_o), 32'd0);
        check("full_valid", 32'(dec_valid_o),  32'd1);
        rst_ni = 1'b0;
        step();
        check("mrst_valid",  32'(dec_valid_o), 32'd0);
        check("mrst_cnt",    inst_cnt_o,       32'd0);
        check("mrst_illcnt", illegal_cnt_o,    32'd0);
        rst_ni = 1'b1; dec_ready = 1'b1;
        step();
        check("mrst_ready", 32'(inst_ready_o), 32'd1);

        // Exhaustive type x func sweep.
        for (int t = 0; t < 8; t++) begin
            for (int f = 0; f < 16; f++) begin
                t3 = 3'(t);
                f4 = 4'(f);
                check_word({17'h0, f4, t3, 8'(t * 16 + f)}, ref_legal(t3, f4), ref_dst(t3, f4));
            end
        end
        step();
        check("sweep_cnt",    inst_cnt_o,    32'd37);
        check("sweep_illcnt", illegal_cnt_o, 32'd91);

        // Hand-computed vector table.
        tl = 0; ti = 0;
        for (int i = 0; i < 14; i++) begin
            check_word(vecs[i].inst, vecs[i].legal, vecs[i].dst);
            if (vecs[i].legal) tl++; else ti++;
        end
        step();
        check("tab_cnt",    inst_cnt_o,    32'(37 + tl));
        check("tab_illcnt", illegal_cnt_o, 32'(91 + ti));

        // Illegal word behind a stalled legal word.
        dec_ready = 1'b0;
        send_word(32'h0000_0D00);
        send_word(32'h0000_0000);
        check("ib_err",   32'(err_o),        32'd1);
        check("ib_ready", 32'(inst_ready_o), 32'd0);
        check("ib_keep",  32'(dec_valid_o),  32'd1);
        check("ib_dst",   32'(dst_sel_o),    32'd3);
        dec_ready = 1'b1;
        step();
        check("ib_drain",  32'(dec_valid_o),  32'd0);
        check("ib_blocked", 32'(inst_ready_o), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ib_clr",      32'(err_o),        32'd0);
        check("ib_ready_up", 32'(inst_ready_o), 32'd1);

        // Clear coinciding with an illegal accept: set wins.
        inst = 32'h0000_1F00; inst_valid = 1'b1; err_clr = 1'b1;
        step();
        inst_valid = 1'b0; err_clr = 1'b0;
        check("sc_err", 32'(err_o), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("sc_clr", 32'(err_o), 32'd0);

        // Two-bit counters saturate.
        inst2 = 32'h0000_0808; valid2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("sat_cnt", 32'(icnt2), 32'((k < 3) ? k : 3));
        end
        valid2 = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hypercorex_inst_decoder.md
# hypercorex_inst_decoder

Registered decode stage between the instruction memory and the HDC core control path. It accepts 32-bit instruction words over a valid/ready handshake, splits them into register fields, classifies each word against the Hypercorex instruction set, and forwards legal words with a destination-class tag. Illegal words are dropped and reported through a sticky error that blocks further fetches. The block has a two-entry skid buffer, so it sustains one instruction per cycle with a registered upstream ready.

## Interface
- CntWidth, 32, width of the saturating accepted-instruction and illegal-instruction counters.
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- inst_i  in  32  instruction word: func [31:11] (only [14:11] decoded), type [10:8], shift_amt [7:6], rs2 [5:4], rs1 [3:2], rd [1:0].
- inst_valid_i  in  1  upstream word valid.
- inst_ready_o  out  1  registered upstream ready.
- dec_valid_o  out  1  decoded word valid.
- dec_ready_i  in  1  downstream ready.
- type_o  out  3  decoded type.
- func_o  out  4  decoded func [14:11].
- rd_o, rs1_o, rs2_o, shift_amt_o  out  2 each  register fields, passed through unchanged.
- dst_sel_o  out  3  destination class: 0 none, 1 reg, 2 bundA, 3 bundB, 4 qhv, 5 am.
- err_o  out  1  sticky illegal-instruction flag.
- err_clr_i  in  1  single-cycle pulse that clears err_o.
- inst_cnt_o  out  CntWidth  count of legal words accepted.
- illegal_cnt_o  out  CntWidth  count of illegal words accepted.

## Operation
- Legal set, as func range per type: 000 → 1..4; 001 → 1..2; 010 → 1..6; 011 → 1..3; 100 → 1..12; 101 → 1..4; 110 → 1..4; 111 → 1..2. Every other combination, including func 0, is illegal. Bits [31:15] are don't-care.
- dst_sel_o by type:
  - 000, 001, 011 → reg.
  - 010: odd func → bundA; even func → bundB.
  - 100: func 1/3/11 → bundA; 2/4/12 → bundB; 5..10 → reg.
  - 101: func 1 → bundB; 2 → bundA; 3 → bundA; 4 → bundB.
  - 110 → qhv.
  - 111 → am.
- Accept means inst_valid_i && inst_ready_o. The field decode is combinational on inst_i and is registered into the output entry. If the output entry is occupied and stalled, the word goes into the skid entry instead.
- Buffer states:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on output handshake with no accept.
  - ONE stays ONE on accept together with output handshake.
  - ONE → FULL on accept with dec_ready_i low.
  - FULL → ONE on output handshake; the skid entry moves to the output entry.
- inst_ready_o next value = (next state ≠ FULL) && !err_next.
- Illegal accepted word:
  - Never enters the buffer.
  - illegal_cnt_o increments.
  - err_o sets on the next edge.
  - inst_ready_o is low from the next cycle until err_clr_i.
  - Entries already buffered still drain normally.
- err_clr_i in the same cycle as an illegal accept: the set wins and err_o stays 1.
- Counters saturate at all-ones and never wrap.
- Output fields hold stable while dec_valid_o && !dec_ready_i.

## Timing
- Reset values: inst_ready_o 0, dec_valid_o 0, all field outputs 0, dst_sel_o 0, err_o 0, both counters 0, state EMPTY.
- inst_ready_o rises on the first edge after rst_ni goes high.
- Latency: a word accepted at edge N appears on dec_valid_o after edge N, i.e. the next cycle.
- Throughput: one word per cycle while dec_ready_i is high.
- dec_ready_i low:
  - At most one extra word is accepted, into the skid entry.
  - inst_ready_o drops the cycle after the skid fills.
  - No word is lost or duplicated.
- err_o and illegal_cnt_o update on the edge of the illegal accept. err_o falls on the edge after err_clr_i.
- Reset mid-operation (rst_ni low at any edge): both entries and all counters clear on that edge, and buffered words are discarded.

## Test plan
- Reset release, then stream one word per cycle with dec_ready_i=1: 0x00000808 then 0x0000207E (type 000 func 1, type 000 func 4) → dec_valid_o the next cycle; dst_sel_o=1 for both; rd_o/rs1_o/rs2_o/shift_amt_o match bits [7:0]; inst_cnt_o=2.
- Backpressure: dec_ready_i=0 while 3 words are offered → 2 accepted, inst_ready_o low; raise dec_ready_i → words emerge in order, then a 3rd is accepted.
- Sweep all type × func (0..15) combinations → exactly 37 legal words forwarded, with dst_sel_o per the rules (e.g. 0x00006400 → type 100 func 12 → 3); illegal_cnt_o=91 (err_clr_i pulsed after each illegal word).
- Illegal 0x00000000 → err_o=1, inst_ready_o=0 from the next cycle, the prior buffered word still delivered; err_clr_i → ready returns the following cycle.
- err_clr_i in the same cycle as an illegal accept → err_o stays 1.
- CntWidth=2: 5 legal words → inst_cnt_o saturates at 3.
- rst_ni low with FULL buffer → dec_valid_o=0 and counters 0 the next cycle.
